adc_poll_ctrl: RTL and testbench
================================

Name: adc_poll_ctrl

Overview:
- Transaction sequencer that sits directly upstream of i2c_master (MAX_BYTES_PER_TRANSACTION=3) and drives its request interface.
- After reset it performs three steps against the ADS1115-class ADC: write the config register, set the pointer to the conversion register, then read the conversion register repeatedly at a fixed interval.
- Publishes each 16-bit signed sample and a one-hot quartile LED indication of the sample.

Parameters:
- SLAVE_ADDR, 7'h48, 7-bit I2C address of the ADC.
- CONFIG_WORD, 16'h8483, value written to the ADC config register (continuous mode).
- POLL_CYCLES, 100000, clk cycles from one read completing to the next read request.
- TIMEOUT_CYCLES, 1000000, maximum clk cycles to wait for transaction_done before aborting.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-high reset.
- enable  in  1  run request; when low, the block parks in IDLE after finishing any open transaction.
- transaction_start  out  1  one-cycle request pulse to i2c_master.
- rd_nwr  out  1  1 = read, 0 = write.
- slave_addr  out  7  always SLAVE_ADDR.
- din  out  8x[0:2]  write bytes; din[0] is sent first.
- transaction_bytes_num  out  2  byte count of the request.
- dout  in  8x[0:2]  read bytes from i2c_master; dout[0] is the MSB.
- transaction_done  in  1  completion pulse from i2c_master.
- sample  out  16  last conversion result, two's complement.
- sample_valid  out  1  one-cycle pulse when sample updates.
- led  out  4  one-hot quartile of sample.
- timeout_count  out  8  saturating count of aborted transactions.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-high, named reset. All state is held in flops clocked by clk and cleared by reset.
- Reset values: state IDLE; transaction_start 0; rd_nwr 0; slave_addr SLAVE_ADDR; din[0..2] 0; transaction_bytes_num 0; sample 0; sample_valid 0; led 4'b0000; timeout_count 0; all counters 0.
- State sequence: IDLE, CFG_REQ, CFG_WAIT, PTR_REQ, PTR_WAIT, INTERVAL, RD_REQ, RD_WAIT.
- IDLE: go to CFG_REQ when enable=1.
- CFG_REQ: drive rd_nwr=0, din = {8'h01, CONFIG_WORD[15:8], CONFIG_WORD[7:0]}, bytes=3, and pulse transaction_start for exactly one cycle; next state CFG_WAIT.
- PTR_REQ: drive rd_nwr=0, din[0]=8'h00, bytes=1; next state PTR_WAIT.
- RD_REQ: drive rd_nwr=1, bytes=2; din is don't-care and held at its previous value; next state RD_WAIT.
- Request stability: rd_nwr, din and bytes are registered and stay stable from the REQ cycle until the matching done is accepted.
- WAIT states: accept transaction_done on the first cycle it is high.
  - CFG_WAIT goes to PTR_REQ.
  - PTR_WAIT goes to INTERVAL.
  - RD_WAIT goes to INTERVAL and, on the next clk edge, loads sample = {dout[0], dout[1]} with sample_valid=1 for one cycle. Latency is 1 cycle from the done pulse.
- transaction_done seen outside a WAIT state is ignored.
- Timeout: a counter runs in every WAIT state and clears on entering a WAIT state. When it reaches TIMEOUT_CYCLES-1 without done:
  - go to CFG_REQ (full re-init) if enable=1, else to IDLE;
  - increment timeout_count, saturating at 255;
  - leave sample unchanged.
- Simultaneous done and timeout in the same cycle: done wins; no increment.
- INTERVAL: counts POLL_CYCLES cycles, then goes to RD_REQ if enable=1, else to IDLE.
- enable falling: the current transaction and its WAIT state complete normally. The next REQ/INTERVAL decision point goes to IDLE. Re-enabling restarts from CFG_REQ.
- LED decode, registered and updated in the same cycle as sample:
  - sample[15]=1 (negative): 4'b0001;
  - otherwise by sample[14:13]: 00 -> 0001, 01 -> 0010, 10 -> 0100, 11 -> 1000.
- Reset mid-transaction: all outputs return to reset values immediately (asynchronous). i2c_master shares the same reset; no done is expected afterwards.

Decomposition:
- Package adc_poll_pkg holds:
  - the state enum;
  - constants PTR_CONV=8'h00 and PTR_CFG=8'h01;
  - byte counts NB_CFG=3, NB_PTR=1, NB_RD=2;
  - the type for the 3-entry 8-bit byte array.
- No sub-module is needed. The LED decode is a small function in the package (adc_quartile_led).

Test Plan:
- Reset, enable=1, done returned 20 cycles after each start -> first start has din=01,84,83, bytes=3, rd_nwr=0; second start has din[0]=00, bytes=1; third start comes POLL_CYCLES cycles later with rd_nwr=1, bytes=2.
- Read returning dout=7F,FF -> sample=16'h7FFF, single sample_valid pulse 1 cycle after done, led=1000. Read returning 20,00 -> led=0010.
- Read returning 80,00 (negative) -> sample=16'h8000, led=0001. Stray done pulse during INTERVAL -> no state change, no sample_valid.
- Withhold done (TIMEOUT_CYCLES=50 in the bench) -> abort after 50 cycles, timeout_count=1, next start is a config write. Done and timeout in the same cycle -> timeout_count unchanged.
- Drop enable during RD_WAIT -> the read completes and updates sample, then IDLE with no further starts. Raise enable -> restart at the config write.
- Assert reset in RD_WAIT -> transaction_start=0, led=0000, sample=0, timeout_count=0 in the same cycle. After release, the sequence restarts at the config write.

Source files
------------

// File: rtl/adc_poll_pkg.sv
// Shared types and constants for the ADS1115-class polling sequencer.
package adc_poll_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCfgReq,
    StCfgWait,
    StPtrReq,
    StPtrWait,
    StInterval,
    StRdReq,
    StRdWait
  } state_e;

  localparam logic [7:0] PTR_CONV = 8'h00;
  localparam logic [7:0] PTR_CFG  = 8'h01;

  localparam logic [1:0] NB_CFG = 2'd3;
  localparam logic [1:0] NB_PTR = 2'd1;
  localparam logic [1:0] NB_RD  = 2'd2;

  typedef logic [7:0] byte_arr_t [0:2];

  // Negative samples share the lowest quartile indication.
  function automatic logic [3:0] adc_quartile_led(input logic [15:0] s);
    logic [3:0] led;
    led = 4'b0001;
    if (!s[15]) begin
      unique case (s[14:13])
        2'b00: led = 4'b0001;
        2'b01: led = 4'b0010;
        2'b10: led = 4'b0100;
        2'b11: led = 4'b1000;
        default: led = 4'b0001;
      endcase
    end
    return led;
  endfunction

endpackage

// File: rtl/adc_poll_ctrl.sv
// Sequencer driving i2c_master: configure the ADC, point at the conversion
// register, then read it back at a fixed interval and publish the sample.
import adc_poll_pkg::*;

module adc_poll_ctrl #(
  parameter logic [6:0]  SLAVE_ADDR     = 7'h48,
  parameter logic [15:0] CONFIG_WORD    = 16'h8483,
  parameter int unsigned POLL_CYCLES    = 100000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic       transaction_start,
  output logic       rd_nwr,
  output logic [6:0] slave_addr,
  output logic [7:0] din [0:2],
  output logic [1:0] transaction_bytes_num,
  input  logic [7:0] dout [0:2],
  input  logic       transaction_done,
  output logic [15:0] sample,
  output logic       sample_valid,
  output logic [3:0] led,
  output logic [7:0] timeout_count
);

  localparam int unsigned CntMax = (POLL_CYCLES > TIMEOUT_CYCLES) ? POLL_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] TmoLast  = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0] PollLast = CntW'(POLL_CYCLES - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            start_q, start_d;
  logic            rd_nwr_q, rd_nwr_d;
  byte_arr_t       din_q, din_d;
  logic [1:0]      bytes_q, bytes_d;
  logic [15:0]     sample_q, sample_d;
  logic            valid_q, valid_d;
  logic [3:0]      led_q, led_d;
  logic [7:0]      tc_q, tc_d;
  logic            wait_expired;
  logic [15:0]     rd_word;
  logic            unused_dout2;

  assign rd_word      = {dout[0], dout[1]};
  assign unused_dout2 = ^dout[2];
  assign wait_expired = (cnt_q == TmoLast);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    start_d  = 1'b0;
    rd_nwr_d = rd_nwr_q;
    din_d    = din_q;
    bytes_d  = bytes_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    led_d    = led_q;
    tc_d     = tc_q;

    unique case (state_q)
      StIdle: begin
        if (enable) state_d = StCfgReq;
      end
      StCfgReq: state_d = StCfgWait;
      StPtrReq: state_d = StPtrWait;
      StRdReq:  state_d = StRdWait;
      StCfgWait, StPtrWait, StRdWait: begin
        cnt_d = cnt_q + 1'b1;
        // A done arriving on the expiry cycle still counts as success.
        if (transaction_done) begin
          if (state_q == StCfgWait) begin
            state_d = enable ? StPtrReq : StIdle;
          end else begin
            state_d = StInterval;
          end
          if (state_q == StRdWait) begin
            sample_d = rd_word;
            valid_d  = 1'b1;
            led_d    = adc_quartile_led(rd_word);
          end
        end else if (wait_expired) begin
          state_d = enable ? StCfgReq : StIdle;
          if (tc_q != 8'hff) tc_d = tc_q + 8'd1;
        end
      end
      StInterval: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == PollLast) state_d = enable ? StRdReq : StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Request fields are loaded on entry so they are valid during the REQ
    // cycle and held through the matching WAIT.
    if (state_d != state_q) begin
      cnt_d = '0;
      case (state_d)
        StCfgReq: begin
          start_d  = 1'b1;
          rd_nwr_d = 1'b0;
          din_d[0] = PTR_CFG;
          din_d[1] = CONFIG_WORD[15:8];
          din_d[2] = CONFIG_WORD[7:0];
          bytes_d  = NB_CFG;
        end
        StPtrReq: begin
          start_d  = 1'b1;
          rd_nwr_d = 1'b0;
          din_d[0] = PTR_CONV;
          bytes_d  = NB_PTR;
        end
        StRdReq: begin
          start_d  = 1'b1;
          rd_nwr_d = 1'b1;
          bytes_d  = NB_RD;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      start_q  <= 1'b0;
      rd_nwr_q <= 1'b0;
      din_q    <= '{default: 8'h00};
      bytes_q  <= 2'd0;
      sample_q <= 16'h0000;
      valid_q  <= 1'b0;
      led_q    <= 4'b0000;
      tc_q     <= 8'h00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      start_q  <= start_d;
      rd_nwr_q <= rd_nwr_d;
      din_q    <= din_d;
      bytes_q  <= bytes_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      led_q    <= led_d;
      tc_q     <= tc_d;
    end
  end

  assign transaction_start     = start_q;
  assign rd_nwr                = rd_nwr_q;
  assign slave_addr            = SLAVE_ADDR;
  assign din                   = din_q;
  assign transaction_bytes_num = bytes_q;
  assign sample                = sample_q;
  assign sample_valid          = valid_q;
  assign led                   = led_q;
  assign timeout_count         = tc_q;

endmodule

// File: tb/tb_adc_poll_ctrl.sv
// Randomized bench for adc_poll_ctrl with a transaction-level reference model.
module tb_adc_poll_ctrl;

  localparam int Poll = 30;
  localparam int Tmo  = 50;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        transaction_start;
  logic        rd_nwr;
  logic [6:0]  slave_addr;
  logic [7:0]  din [0:2];
  logic [1:0]  transaction_bytes_num;
  logic [7:0]  dout [0:2];
  logic        transaction_done;
  logic [15:0] sample;
  logic        sample_valid;
  logic [3:0]  led;
  logic [7:0]  timeout_count;

  adc_poll_ctrl #(
    .SLAVE_ADDR     (7'h48),
    .CONFIG_WORD    (16'h8483),
    .POLL_CYCLES    (Poll),
    .TIMEOUT_CYCLES (Tmo)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .enable                (enable),
    .transaction_start     (transaction_start),
    .rd_nwr                (rd_nwr),
    .slave_addr            (slave_addr),
    .din                   (din),
    .transaction_bytes_num (transaction_bytes_num),
    .dout                  (dout),
    .transaction_done      (transaction_done),
    .sample                (sample),
    .sample_valid          (sample_valid),
    .led                   (led),
    .timeout_count         (timeout_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [15:0] m_sample = 16'h0;
  logic [7:0]  m_tc     = 8'h0;
  logic [7:0]  m_din [0:2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [3:0] ref_led(input logic [15:0] s);
    int v;
    v = $signed(s);
    if (v < 0) return 4'b0001;
    return 4'(1 << (v / 8192));
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  // Waits for a start pulse; optionally fires one stray done while waiting.
  task automatic wait_start(input int limit, input int stray_at, output int waited);
    bit saw_valid;
    waited    = 0;
    saw_valid = 1'b0;
    while (!transaction_start && waited < limit) begin
      transaction_done = (waited == stray_at);
      tick();
      waited++;
      if (sample_valid) saw_valid = 1'b1;
    end
    transaction_done = 1'b0;
    check("start_seen", transaction_start, 1);
    if (stray_at >= 0) check("stray_no_valid", saw_valid, 0);
  endtask

  // kind: 0 config write, 1 pointer write, 2 conversion read
  task automatic check_req(input int kind);
    logic [2:0] exp_ctl;
    if (kind == 0) begin
      m_din[0] = 8'h01; m_din[1] = 8'h84; m_din[2] = 8'h83;
      exp_ctl = {1'b0, 2'd3};
    end else if (kind == 1) begin
      m_din[0] = 8'h00;
      exp_ctl = {1'b0, 2'd1};
    end else begin
      exp_ctl = {1'b1, 2'd2};
    end
    check($sformatf("req%0d_ctl", kind), {rd_nwr, transaction_bytes_num}, exp_ctl);
    check($sformatf("req%0d_din", kind), {din[0], din[1], din[2]},
          {m_din[0], m_din[1], m_din[2]});
    check("slave_addr", slave_addr, 7'h48);
    tick();
    check("start_one_cycle", transaction_start, 0);
    check($sformatf("req%0d_hold", kind), {rd_nwr, transaction_bytes_num, din[0]},
          {exp_ctl, m_din[0]});
  endtask

  task automatic respond(input int delay, input logic [7:0] hi, input logic [7:0] lo,
                         input int kind);
    repeat (delay) tick();
    transaction_done = 1'b1;
    dout[0] = hi; dout[1] = lo; dout[2] = 8'($urandom);
    tick();
    transaction_done = 1'b0;
    if (kind == 2) begin
      m_sample = {hi, lo};
      check("valid_pulse", sample_valid, 1);
      check("sample", sample, m_sample);
      check("led", led, ref_led(m_sample));
      tick();
      check("valid_one_cycle", sample_valid, 0);
    end else begin
      check("write_no_valid", sample_valid, 0);
    end
  endtask

  task automatic txn(input int kind, input int exp_gap, input int stray, input int delay,
                     input logic [7:0] hi, input logic [7:0] lo);
    int w;
    wait_start(exp_gap + 20, stray, w);
    check($sformatf("gap_kind%0d", kind), w, exp_gap);
    check_req(kind);
    respond(delay, hi, lo, kind);
  endtask

  initial begin
    int w;
    int starts;
    reset = 1'b1;
    enable = 1'b0;
    transaction_done = 1'b0;
    dout = '{default: 8'h00};
    m_din = '{default: 8'h00};
    repeat (3) tick();
    check("rst_start", transaction_start, 0);
    check("rst_ctl", {rd_nwr, transaction_bytes_num, din[0], din[1], din[2]}, 0);
    check("rst_out", {sample, sample_valid, led, timeout_count}, 0);
    check("rst_addr", slave_addr, 7'h48);
    reset = 1'b0;
    repeat (3) tick();
    check("idle_disabled", transaction_start, 0);

    // Bring-up with done 20 cycles after each start
    enable = 1'b1;
    txn(0, 1, -1, 19, 8'h00, 8'h00);
    txn(1, 0, -1, 19, 8'h00, 8'h00);
    txn(2, Poll, -1, 19, 8'h7f, 8'hff);
    check("led_top", led, 4'b1000);
    txn(2, Poll - 1, -1, int'($urandom_range(1, 30)), 8'h20, 8'h00);
    check("led_q1", led, 4'b0010);
    txn(2, Poll - 1, 7, int'($urandom_range(1, 30)), 8'h80, 8'h00);
    check("led_neg", led, 4'b0001);

    for (int i = 0; i < 8; i++) begin
      int st;
      st = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, Poll - 6)) : -1;
      txn(2, Poll - 1, st, int'($urandom_range(1, 30)), 8'($urandom), 8'($urandom));
    end

    // Withheld done -> abort and full re-init
    wait_start(Poll + 20, -1, w);
    check("gap_pre_tmo", w, Poll - 1);
    check_req(2);
    wait_start(Tmo + 20, -1, w);
    m_tc = m_tc + 8'd1;
    check("tmo_gap", w, Tmo);
    check("tmo_count", timeout_count, m_tc);
    check("tmo_sample_kept", sample, m_sample);
    check_req(0);
    respond(5, 8'h00, 8'h00, 0);
    txn(1, 0, -1, 5, 8'h00, 8'h00);

    // Done on the last permitted wait cycle wins over the timeout
    txn(2, Poll, -1, Tmo - 1, 8'($urandom), 8'($urandom));
    check("tie_count", timeout_count, m_tc);

    // Drop enable while the read is open
    wait_start(Poll + 20, -1, w);
    check("gap_pre_disable", w, Poll - 1);
    check_req(2);
    enable = 1'b0;
    respond(5, 8'h12, 8'h34, 2);
    starts = 0;
    repeat (Poll + 40) begin
      tick();
      if (transaction_start) starts++;
    end
    check("disabled_no_start", starts, 0);
    enable = 1'b1;
    txn(0, 1, -1, 5, 8'h00, 8'h00);
    txn(1, 0, -1, 5, 8'h00, 8'h00);

    // Asynchronous reset during a read
    wait_start(Poll + 20, -1, w);
    check("gap_pre_reset", w, Poll);
    check_req(2);
    repeat (3) tick();
    #1 reset = 1'b1;
    #1;
    m_sample = 16'h0;
    m_tc = 8'h0;
    m_din = '{default: 8'h00};
    check("arst_start", transaction_start, 0);
    check("arst_led", led, 4'b0000);
    check("arst_sample", sample, m_sample);
    check("arst_tc", timeout_count, m_tc);
    check("arst_ctl", {rd_nwr, transaction_bytes_num, din[0]}, 0);
    tick();
    reset = 1'b0;
    txn(0, 1, -1, 5, 8'h00, 8'h00);
    txn(1, 0, -1, 5, 8'h00, 8'h00);
    txn(2, Poll, -1, 3, 8'h5a, 8'ha5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
